// File: rtl/pc_seq_if.sv
// ---------------------------------------------------------------------------
// pc_seq_if : decode/branch-unit <-> PC sequencer bundle.
//   master : upstream side, drives the redirect decode and stall, observes PC.
//   slave  : the sequencer, consumes the decode and drives PC and status.
// Signals:
//   stall, condition_met, jump, jump_reg   control from decode/branch unit
//   instr_index[25:0], imm[15:0]           instruction target fields
//   reg_target[31:0]                       rs value for JR/JALR
//   pc, link_addr                          current and return addresses
//   in_delay_slot, active, addr_err        sequencer status
// ---------------------------------------------------------------------------
interface pc_seq_if;
    logic        stall;
    logic        condition_met;
    logic        jump;
    logic        jump_reg;
    logic [25:0] instr_index;
    logic [15:0] imm;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        in_delay_slot;
    logic        active;
    logic        addr_err;

    modport master (
        output stall, condition_met, jump, jump_reg, instr_index, imm, reg_target,
        input  pc, link_addr, in_delay_slot, active, addr_err
    );

    modport slave (
        input  stall, condition_met, jump, jump_reg, instr_index, imm, reg_target,
        output pc, link_addr, in_delay_slot, active, addr_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer : program-counter stage with one MIPS branch-delay slot.
// A redirect (JR/JALR > J/JAL > taken branch) latches its target; the next
// instruction (pc+4) executes as the delay slot, then the PC loads the target.
// Landing on HALT_ADDR through a redirect halts the CPU until reset.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc_seq_if.slave (decode inputs in, pc/link/status out)
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input logic     clk,
    input logic     reset,
    pc_seq_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_DELAY, S_HALTED} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_off   = {{14{bus.imm[15]}}, bus.imm, 2'b00};
    assign redirect = bus.jump_reg | bus.jump | bus.condition_met;

    always_comb begin
        if (bus.jump_reg)  target = bus.reg_target;
        else if (bus.jump) target = {pc_plus4[31:28], bus.instr_index, 2'b00};
        else               target = pc_plus4 + br_off;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        addr_err_d = 1'b0;   // pulse: cleared on any cycle that does not latch a bad JR
        if (!bus.stall) begin
            case (state_q)
                S_RUN: begin
                    pc_d = pc_plus4;
                    if (redirect) begin
                        target_d   = target;
                        state_d    = S_DELAY;
                        addr_err_d = bus.jump_reg && (bus.reg_target[1:0] != 2'b00);
                    end
                end
                S_DELAY: begin
                    // Redirect inputs here are ignored: branch-in-delay-slot unsupported.
                    pc_d    = target_q;
                    state_d = (target_q == HALT_ADDR) ? S_HALTED : S_RUN;
                end
                default: ;   // halted: everything frozen until reset
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_VECTOR;
            target_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.link_addr     = pc_q + 32'd8;
    assign bus.in_delay_slot = (state_q == S_DELAY);
    assign bus.active        = (state_q != S_HALTED);
    assign bus.addr_err      = addr_err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer : directed scenarios plus randomized traffic, compared every
// cycle against a queue-based reference model of the sequencing rules.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;
    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] HALT = 32'h00000000;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pc_seq_if bus ();

    pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(HALT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: a pending-target queue; non-empty means "in delay slot".
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic        m_halt;
    logic        m_aerr;
    int          aerr_pulses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic st, input logic cm,
                                input logic j, input logic jr, input logic [25:0] idx,
                                input logic [15:0] im, input logic [31:0] rt);
        logic [31:0] p4, tgt;
        if (rst) begin
            m_pc = RV; m_pend.delete(); m_halt = 0; m_aerr = 0;
        end else if (st || m_halt) begin
            m_aerr = 0;
        end else if (m_pend.size() != 0) begin
            m_pc   = m_pend.pop_front();
            m_halt = (m_pc == HALT);
            m_aerr = 0;
        end else begin
            p4 = m_pc + 4;
            if (jr)      tgt = rt;
            else if (j)  tgt = {p4[31:28], idx, 2'b00};
            else         tgt = p4 + 32'($signed(im)) * 4;
            m_aerr = jr && (rt % 4 != 0);
            if (jr || j || cm) m_pend.push_back(tgt);
            m_pc = p4;
        end
    endtask

    // One clock: apply inputs, advance, then compare all outputs to the model.
    task automatic step(input logic rst, input logic st, input logic cm, input logic j,
                        input logic jr, input logic [25:0] idx, input logic [15:0] im,
                        input logic [31:0] rt);
        reset = rst; bus.stall = st; bus.condition_met = cm; bus.jump = j;
        bus.jump_reg = jr; bus.instr_index = idx; bus.imm = im; bus.reg_target = rt;
        @(posedge clk);
        #1;
        model_update(rst, st, cm, j, jr, idx, im, rt);
        if (bus.addr_err === 1'b1) aerr_pulses++;
        chk("pc",        bus.pc,            m_pc);
        chk("link_addr", bus.link_addr,     m_pc + 32'd8);
        chk("delay",     32'(bus.in_delay_slot), 32'(m_pend.size() != 0));
        chk("active",    32'(bus.active),   32'(!m_halt));
        chk("addr_err",  32'(bus.addr_err), 32'(m_aerr));
    endtask

    task automatic adv(); step(0, 0, 0, 0, 0, '0, '0, '0); endtask

    initial begin
        m_pc = RV; m_halt = 0; m_aerr = 0; aerr_pulses = 0;

        // 1: reset then sequential fetch
        step(1, 0, 0, 0, 0, '0, '0, '0);
        chk("rst_pc", bus.pc, 32'hBFC00000);
        chk("rst_active", 32'(bus.active), 32'd1);
        adv(); chk("seq1", bus.pc, 32'hBFC00004);
        adv(); chk("seq2", bus.pc, 32'hBFC00008);
        adv(); chk("seq3", bus.pc, 32'hBFC0000C);
        adv(); chk("seq4", bus.pc, 32'hBFC00010);

        // 2: backward branch, imm = -2 words
        step(0, 0, 1, 0, 0, '0, 16'hFFFE, '0);
        chk("br_slot_pc", bus.pc, 32'hBFC00014);
        chk("br_slot_flag", 32'(bus.in_delay_slot), 32'd1);
        adv(); chk("br_tgt", bus.pc, 32'hBFC0000C);
        repeat (5) adv();
        chk("pre_j", bus.pc, 32'hBFC00020);

        // 3: J-type
        step(0, 0, 0, 1, 0, 26'h0000040, '0, '0);
        chk("j_slot", bus.pc, 32'hBFC00024);
        adv(); chk("j_tgt", bus.pc, 32'hB0000100);

        // 5: stall inside DELAY, misaligned JR
        step(0, 0, 0, 0, 1, '0, '0, 32'h00001002);
        chk("jr_slot", bus.pc, 32'hB0000104);
        chk("jr_aerr", 32'(bus.addr_err), 32'd1);
        repeat (3) begin
            step(0, 1, 1, 1, 1, 26'h3FFFFFF, 16'h1234, 32'hDEADBEEC);
            chk("stall_pc", bus.pc, 32'hB0000104);
            chk("stall_ds", 32'(bus.in_delay_slot), 32'd1);
        end
        step(0, 0, 1, 1, 1, 26'h1, 16'h1, 32'h8);   // ignored in delay slot
        chk("jr_tgt", bus.pc, 32'h00001002);
        chk("jr_active", 32'(bus.active), 32'd1);
        chk("aerr_once", 32'(aerr_pulses), 32'd1);

        // 6: reset beats stall while in DELAY
        step(0, 0, 0, 1, 0, 26'h10, '0, '0);
        step(1, 1, 0, 0, 0, '0, '0, '0);
        chk("rst_dly_pc", bus.pc, 32'hBFC00000);
        chk("rst_dly_ds", 32'(bus.in_delay_slot), 32'd0);
        chk("rst_dly_act", 32'(bus.active), 32'd1);

        // 4: JR to HALT_ADDR
        step(0, 0, 0, 0, 1, '0, '0, 32'h0);
        chk("halt_slot", bus.pc, 32'hBFC00004);
        adv(); chk("halt_pc", bus.pc, 32'h0);
        chk("halt_act", 32'(bus.active), 32'd0);
        repeat (4) step(0, 0, 1, 1, 1, 26'h2AAAAAA, 16'h0040, 32'h1000);
        chk("halt_hold", bus.pc, 32'h0);

        // Randomized traffic against the model
        step(1, 0, 0, 0, 0, '0, '0, '0);
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_st, r_cm, r_j, r_jr;
            logic [31:0] r_rt;
            r_rst = ($urandom_range(0, 59) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_cm  = ($urandom_range(0, 4) == 0);
            r_j   = ($urandom_range(0, 7) == 0);
            r_jr  = ($urandom_range(0, 7) == 0);
            r_rt  = ($urandom_range(0, 15) == 0) ? 32'h0 : 32'($urandom);
            step(r_rst, r_st, r_cm, r_j, r_jr, 26'($urandom), 16'($urandom), r_rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
